clock_display_scan: RTL and testbench

Six-digit multiplexed seven-segment scan driver for the digital clock. It sits directly downstream of the BCD time counters, which supply hour, minute and second digits. It snapshots all six digits once per scan frame so the display never tears. It then drives one common-anode digit at a time, with per-digit blink, decimal point, invalid-code dash and hour-tens leading-zero blanking.

---
 rtl/clock_display_scan.sv | 124 ++++++++++++
 tb/tb_clock_display_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Six-digit common-anode seven-segment scan driver with per-frame digit snapshot,
// per-digit blink and decimal point, invalid-code dash and hour-tens blanking.
module clock_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        EN,
  input  logic [23:0] D,
  input  logic [5:0]  BLINK,
  input  logic [5:0]  DP,
  output logic [5:0]  AN,
  output logic [6:0]  SEG,
  output logic        DPo,
  output logic        FRAME
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_slot;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [23:0]   r_sh_d;
  logic [5:0]    r_sh_blink;
  logic [5:0]    r_sh_dp;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dpo;
  logic          r_frame;

  logic          w_tick;
  logic          w_frame_start;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg;
  logic [5:0]    w_an;

  // Active-low {g..a} pattern; codes above 9 render as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  assign w_tick        = EN && (r_cnt == CNT_MAX);
  assign w_frame_start = w_tick && (r_slot == 3'd5);
  assign w_digit       = r_sh_d[{r_slot, 2'b00} +: 4];
  assign w_blank       = (r_blink_phase && r_sh_blink[r_slot]) ||
                         (LZ_BLANK && (r_slot == 3'd5) && (w_digit == 4'd0));
  assign w_seg         = seg_decode(w_digit);

  always_comb begin
    w_an = 6'b111111;
    if (EN) begin
      w_an = ~(6'b000001 << r_slot);
    end else begin
      w_an = 6'b111111;
    end
  end

  // Outputs reflect the slot/shadow state present before this edge, so the
  // first digit of a new frame already uses the fresh snapshot.
  always_ff @(posedge CP) begin
    if (CR) begin
      r_cnt         <= '0;
      r_slot        <= 3'd0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_sh_d        <= 24'h000000;
      r_sh_blink    <= 6'b000000;
      r_sh_dp       <= 6'b000000;
      r_an          <= 6'b111111;
      r_seg         <= 7'b1111111;
      r_dpo         <= 1'b1;
      r_frame       <= 1'b0;
    end else begin
      r_an    <= w_an;
      r_seg   <= w_blank ? 7'b1111111 : w_seg;
      r_dpo   <= w_blank | ~r_sh_dp[r_slot];
      r_frame <= w_frame_start;
      if (EN) begin
        r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      end
      if (w_tick) begin
        r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
      end
      if (w_frame_start) begin
        r_sh_d     <= D;
        r_sh_blink <= BLINK;
        r_sh_dp    <= DP;
        if (r_frame_cnt == FRM_MAX) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  assign AN    = r_an;
  assign SEG   = r_seg;
  assign DPo   = r_dpo;
  assign FRAME = r_frame;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: constant vector table, directed
// corner sequences and randomized traffic against a cycle-count based model.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        CP = 1'b0;
  logic        CR = 1'b1;
  logic        EN = 1'b0;
  logic [23:0] D = 24'h000000;
  logic [5:0]  BLINK = 6'b000000;
  logic [5:0]  DP = 6'b000000;
  logic [5:0]  AN, AN0;
  logic [6:0]  SEG, SEG0;
  logic        DPo, DPo0, FRAME, FRAME0;

  int checks = 0;
  int errors = 0;

  // Model: enabled cycles since reset (mod one frame), snapshots taken so far.
  int          m_e = 0;
  int          m_frames = 0;
  logic [23:0] m_sd = 24'h000000;
  logic [5:0]  m_sb = 6'b000000;
  logic [5:0]  m_sdp = 6'b000000;
  logic [6:0]  dec_tbl [0:15];

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1'b1)) dut (
    .CP(CP), .CR(CR), .EN(EN), .D(D), .BLINK(BLINK), .DP(DP),
    .AN(AN), .SEG(SEG), .DPo(DPo), .FRAME(FRAME));

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1'b0)) dut_nolz (
    .CP(CP), .CR(CR), .EN(EN), .D(D), .BLINK(BLINK), .DP(DP),
    .AN(AN0), .SEG(SEG0), .DPo(DPo0), .FRAME(FRAME0));

  always #5 CP = ~CP;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_slot();
    return (m_e / SD) % 6;
  endfunction

  // One clock: predict outputs from the model, clock, advance model, compare.
  task automatic cyc();
    int         slot;
    logic       tick, ph, bl;
    logic [3:0] dig;
    logic [5:0] e_an;
    logic [6:0] e_seg1, e_seg0;
    logic       e_dpo1, e_dpo0, e_fr;
    slot = m_slot();
    tick = EN && ((m_e % SD) == SD - 1);
    dig  = m_sd[slot*4 +: 4];
    ph   = ((m_frames / BF) % 2) == 1;
    bl   = ph && m_sb[slot];
    if (CR) begin
      e_an = 6'h3f; e_seg1 = 7'h7f; e_seg0 = 7'h7f; e_dpo1 = 1'b1; e_dpo0 = 1'b1; e_fr = 1'b0;
    end else begin
      e_an   = EN ? ~(6'd1 << slot) : 6'h3f;
      e_seg0 = bl ? 7'h7f : dec_tbl[dig];
      e_dpo0 = bl ? 1'b1 : ~m_sdp[slot];
      e_seg1 = (bl || (slot == 5 && dig == 4'd0)) ? 7'h7f : dec_tbl[dig];
      e_dpo1 = (bl || (slot == 5 && dig == 4'd0)) ? 1'b1 : ~m_sdp[slot];
      e_fr   = tick && (slot == 5);
    end
    @(posedge CP);
    #1;
    if (CR) begin
      m_e = 0; m_frames = 0; m_sd = 24'h0; m_sb = 6'h0; m_sdp = 6'h0;
    end else if (EN) begin
      if (tick && slot == 5) begin
        m_frames++;
        m_sd = D; m_sb = BLINK; m_sdp = DP;
      end
      m_e = (m_e + 1) % (6 * SD);
    end
    check("an", {26'd0, AN}, {26'd0, e_an});
    check("seg", {25'd0, SEG}, {25'd0, e_seg1});
    check("dpo", {31'd0, DPo}, {31'd0, e_dpo1});
    check("frame", {31'd0, FRAME}, {31'd0, e_fr});
    check("an_nolz", {26'd0, AN0}, {26'd0, e_an});
    check("seg_nolz", {25'd0, SEG0}, {25'd0, e_seg0});
    check("dpo_nolz", {31'd0, DPo0}, {31'd0, e_dpo0});
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!FRAME && n < 100);
    check("frame_wait", {31'd0, FRAME}, 32'd1);
  endtask

  typedef struct {
    logic        cr;
    logic        en;
    logic [23:0] d;
    int          ncyc;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        frame;
  } vec_t;

  vec_t vt [12];

  initial begin
    int n;
    int blank_cnt;
    dec_tbl[0] = 7'b1000000; dec_tbl[1] = 7'b1111001; dec_tbl[2] = 7'b0100100;
    dec_tbl[3] = 7'b0110000; dec_tbl[4] = 7'b0011001; dec_tbl[5] = 7'b0010010;
    dec_tbl[6] = 7'b0000010; dec_tbl[7] = 7'b1111000; dec_tbl[8] = 7'b0000000;
    dec_tbl[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec_tbl[i] = 7'b0111111;

    // Reset, then scan of 23:59:59 with D cleared mid-frame during slot 2.
    vt[0]  = '{1'b1, 1'b1, 24'h235959,  2, 6'h3f, 7'h7f, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 24'h235959,  1, 6'h3e, 7'h40, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 24'h235959, 23, 6'h1f, 7'h7f, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 24'h235959,  4, 6'h3e, 7'h10, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 24'h235959,  4, 6'h3d, 7'h12, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 24'h235959,  2, 6'h3b, 7'h10, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 24'h000000,  2, 6'h3b, 7'h10, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 24'h000000,  4, 6'h37, 7'h12, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 24'h000000,  4, 6'h2f, 7'h30, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 24'h000000,  4, 6'h1f, 7'h24, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b1, 24'h000000,  4, 6'h3e, 7'h40, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 24'h000000, 20, 6'h1f, 7'h7f, 1'b1, 1'b1};

    @(negedge CP);
    for (int i = 0; i < 12; i++) begin
      CR = vt[i].cr; EN = vt[i].en; D = vt[i].d;
      repeat (vt[i].ncyc) cyc();
      check("tbl_an", {26'd0, AN}, {26'd0, vt[i].an});
      check("tbl_seg", {25'd0, SEG}, {25'd0, vt[i].seg});
      check("tbl_dpo", {31'd0, DPo}, {31'd0, vt[i].dpo});
      check("tbl_frame", {31'd0, FRAME}, {31'd0, vt[i].frame});
    end

    // Invalid code in digit 1 with its decimal point requested.
    D = 24'h0000C0; DP = 6'b000010;
    wait_frame();
    repeat (8) cyc();
    check("inv_an", {26'd0, AN}, 32'h3d);
    check("inv_seg", {25'd0, SEG}, 32'h3f);
    check("inv_dpo", {31'd0, DPo}, 32'd0);
    repeat (4) cyc();
    check("dp_other", {31'd0, DPo}, 32'd1);

    // Blink on digit 0: over 8 frames exactly half show it blanked.
    D = 24'h012345; DP = 6'b000000; BLINK = 6'b000001;
    blank_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      wait_frame();
      cyc();
      if (SEG == 7'h7f) blank_cnt++;
    end
    check("blink_count", blank_cnt, 32'd4);
    BLINK = 6'b000000;

    // EN dropped during slot 3, then resumed; later reset mid-frame at slot 4.
    n = 0;
    while (m_slot() != 3 && n < 50) begin cyc(); n++; end
    EN = 1'b0;
    cyc();
    check("en_off_an", {26'd0, AN}, 32'h3f);
    repeat (3) cyc();
    EN = 1'b1;
    cyc();
    check("en_resume_an", {26'd0, AN}, 32'h37);
    n = 0;
    while (m_slot() != 4 && n < 50) begin cyc(); n++; end
    CR = 1'b1;
    cyc();
    check("mid_rst_an", {26'd0, AN}, 32'h3f);
    check("mid_rst_seg", {25'd0, SEG}, 32'h7f);
    check("mid_rst_dpo", {31'd0, DPo}, 32'd1);
    check("mid_rst_frame", {31'd0, FRAME}, 32'd0);
    CR = 1'b0;
    cyc();
    check("post_rst_an", {26'd0, AN}, 32'h3e);
    check("post_rst_seg", {25'd0, SEG}, 32'h40);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      CR = ($urandom_range(0, 299) == 0);
      EN = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) D = 24'($urandom);
      if ($urandom_range(0, 15) == 0) BLINK = 6'($urandom);
      if ($urandom_range(0, 15) == 0) DP = 6'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
